// File: rtl/up_down_count.sv
// -----------------------------------------------------------------------------
// up_down_count
//
// Purpose:
//   Up/down counter with a combinational seven-segment decode of its value.
//   By default it is a decade counter (0-9). Defining the macro
//   UPDOWN_COUNT_HEX_EN turns it into a modulo-16 counter (0-15) with
//   hexadecimal glyphs for A-F.
//
// Ports:
//   clk        in   1  single clock, state updates on the rising edge
//   reset      in   1  asynchronous, active-low; 0 clears count immediately
//   mode       in   1  direction: 0 = count up, 1 = count down
//   count      out  4  registered counter value
//   BCD_output out  7  active-high segments {a,b,c,d,e,f,g} of count
//
// Configuration macro:
//   UPDOWN_COUNT_HEX_EN  defined   -> modulo-16, hex decode for 10-15
//                        undefined -> modulo-10, 10-15 decode as a dash
// -----------------------------------------------------------------------------
module up_down_count (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode,
    output logic [3:0] count,
    output logic [6:0] BCD_output
);

`ifdef UPDOWN_COUNT_HEX_EN
    localparam logic [3:0] MAX_VAL = 4'd15;
`else
    localparam logic [3:0] MAX_VAL = 4'd9;
`endif

    logic [3:0] count_next;

    // Segment pattern for one counter value; bit6=a ... bit0=g.
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h7E;
            4'd1:    s = 7'h30;
            4'd2:    s = 7'h6D;
            4'd3:    s = 7'h79;
            4'd4:    s = 7'h33;
            4'd5:    s = 7'h5B;
            4'd6:    s = 7'h5F;
            4'd7:    s = 7'h70;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h7B;
`ifdef UPDOWN_COUNT_HEX_EN
            4'd10:   s = 7'h77;
            4'd11:   s = 7'h1F;
            4'd12:   s = 7'h4E;
            4'd13:   s = 7'h3D;
            4'd14:   s = 7'h4F;
            4'd15:   s = 7'h47;
`endif
            // Values outside the decade range show only segment g.
            default: s = 7'h01;
        endcase
        return s;
    endfunction

    // Next-value logic: wrap at both ends, no special handling for a
    // direction change at the wrap point.
    always_comb begin
        count_next = 4'd0;
        if (mode == 1'b0) begin
            count_next = (count == MAX_VAL) ? 4'd0 : count + 4'd1;
        end else begin
            count_next = (count == 4'd0) ? MAX_VAL : count - 4'd1;
        end
`ifndef UPDOWN_COUNT_HEX_EN
        // Recovery: an out-of-range value (10-15) reloads 0 in either direction.
        if (count > MAX_VAL) begin
            count_next = 4'd0;
        end
`endif
    end

    // Count register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 4'd0;
        end else begin
            count <= count_next;
        end
    end

    // Zero-latency decode of the registered value
    always_comb begin
        BCD_output = seg_decode(count);
    end

endmodule

// File: tb/tb_up_down_count.sv
// -----------------------------------------------------------------------------
// tb_up_down_count
//
// Purpose:
//   Self-checking bench for up_down_count. Directed stimulus pushes the
//   hand-computed expected {count, segments} into a scoreboard queue; a
//   monitor pops and compares one entry 1 ns after every rising clock edge,
//   or after an asynchronous reset is applied between edges.
//   Expectations follow UPDOWN_COUNT_HEX_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_up_down_count;

`ifdef UPDOWN_COUNT_HEX_EN
    localparam int MAXV   = 15;
    localparam int N_UP   = 16;
    localparam logic [6:0] SEG [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B,
                                        7'h5F, 7'h70, 7'h7F, 7'h7B, 7'h77, 7'h1F,
                                        7'h4E, 7'h3D, 7'h4F, 7'h47};
`else
    localparam int MAXV   = 9;
    localparam int N_UP   = 12;
    localparam logic [6:0] SEG [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B,
                                        7'h5F, 7'h70, 7'h7F, 7'h7B, 7'h01, 7'h01,
                                        7'h01, 7'h01, 7'h01, 7'h01};
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       mode;
    logic [3:0] count;
    logic [6:0] BCD_output;

    logic [10:0] exp_q  [$];
    string       name_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;
    event        async_ev;

    up_down_count dut (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode),
        .count      (count),
        .BCD_output (BCD_output)
    );

    always #5 clk = ~clk;

    task automatic expect_val(input int v, input string nm);
        logic [3:0] c;
        c = v[3:0];
        exp_q.push_back({c, SEG[c]});
        name_q.push_back(nm);
    endtask

    // Drive mode on the falling edge; the value is checked after the next rise.
    task automatic step(input logic m, input int v, input string nm);
        @(negedge clk);
        mode = m;
        expect_val(v, nm);
    endtask

    task automatic release_step(input logic m, input int v, input string nm);
        @(negedge clk);
        reset = 1'b1;
        mode  = m;
        expect_val(v, nm);
    endtask

    // Reset applied between edges and checked before the next rising edge.
    task automatic async_reset(input string nm);
        @(negedge clk);
        #2;
        reset = 1'b0;
        expect_val(0, nm);
        ->async_ev;
    endtask

    // Monitor
    initial begin
        logic [10:0] e;
        string       nm;
        forever begin
            @(posedge clk or async_ev);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_tests++;
                if ({count, BCD_output} !== e) begin
                    n_fail++;
                    $display("FAIL %s: count=%h seg=%h, expected count=%h seg=%h",
                             nm, count, BCD_output, e[10:7], e[6:0]);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        reset = 1'b0;
        mode  = 1'b0;

        // Held in reset while the clock runs
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            reset = 1'b0;
            expect_val(0, "reset_hold");
        end

        // Count up through the wrap point
        release_step(1'b0, 1, "release_up");
        for (int i = 2; i <= N_UP; i++) begin
            step(1'b0, i % (MAXV + 1), "count_up");
        end

        // Asynchronous reset, then up to 5 and reset again mid-count
        async_reset("async_reset");
        step(1'b0, 0, "reset_hold2");
        release_step(1'b0, 1, "release_up2");
        for (int i = 2; i <= 5; i++) begin
            step(1'b0, i, "up_to_5");
        end
        async_reset("async_reset_at5");
        step(1'b0, 0, "reset_hold3");

        // Release counting down: wraps from 0 to the maximum
        release_step(1'b1, MAXV, "release_down");
        step(1'b1, MAXV - 1, "count_down");
        step(1'b1, MAXV - 2, "count_down");

        // Direction reversal at the maximum
        step(1'b0, MAXV - 1, "up_again");
        step(1'b0, MAXV, "up_to_max");
        step(1'b1, MAXV - 1, "reverse_at_max");

        // Down to 3, then toggle mode each edge
        for (int v = MAXV - 2; v >= 3; v--) begin
            step(1'b1, v, "down_to_3");
        end
        step(1'b0, 4, "toggle");
        step(1'b1, 3, "toggle");
        step(1'b0, 4, "toggle");
        step(1'b1, 3, "toggle");

        // Direction reversal at zero
        step(1'b1, 2, "down_to_0");
        step(1'b1, 1, "down_to_0");
        step(1'b1, 0, "down_to_0");
        step(1'b0, 1, "reverse_at_0");

        // Let the monitor drain, then confirm nothing was left unchecked
        repeat (3) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/up_down_count.md
UP_DOWN_COUNT -- requirements
Module: up_down_count

Interface
REQ-001 Parameters SHALL be none; all behaviour is fixed or selected by the Configuration macro.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; reset=0 clears state immediately, reset=1 allows counting.
REQ-004 mode  input  1  direction select; 0 = count up, 1 = count down.
REQ-005 count  output  4  current counter value, registered.
REQ-006 BCD_output  output  7  active-high seven-segment pattern of count; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.

Function
REQ-007 The counter SHALL update on every rising clk edge while reset=1; there is no enable.
REQ-008 mode SHALL be sampled at the rising clk edge; a change takes effect on the next edge with no pipeline delay.
REQ-009 Up (mode=0): count SHALL increment by 1; at the maximum value it SHALL wrap to 0 on the next edge.
REQ-010 Down (mode=1): count SHALL decrement by 1; at 0 it SHALL wrap to the maximum value on the next edge.
REQ-011 Maximum value SHALL be 9 (decade counter) by default, or 15 per REQ-020.
REQ-012 In decade mode, count SHALL never hold 10-15; any illegal value SHALL load 0 on the next edge in either direction.
REQ-013 BCD_output SHALL be a purely combinational decode of count, with zero cycles of latency relative to count.
REQ-014 Decode, hex: 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B.
REQ-015 Decode, for values 10-15: in hex mode A=77, b=1F, C=4E, d=3D, E=4F, F=47; in decade mode 10-15 SHALL decode to 01 (segment g only, error dash).
REQ-016 A direction reversal at the wrap point SHALL take no special action; for example, count=9 with mode switched to 1 SHALL give 8 on the next edge.
REQ-017 Outputs SHALL never be X after the first reset assertion, regardless of mode history.

Reset
REQ-018 Asserting reset=0 SHALL force count=0 and BCD_output=7E asynchronously, without waiting for clk, including mid-count.
REQ-019 On release (reset 0->1), the first rising edge SHALL advance count from 0 according to mode: to 1 (up) or to the maximum value (down).

Configuration
REQ-020 Macro UPDOWN_COUNT_HEX_EN: when defined, the counter SHALL be modulo-16 (0-15, maximum 15) and REQ-012 SHALL not apply.
REQ-021 Without UPDOWN_COUNT_HEX_EN, the counter SHALL be a modulo-10 decade counter (0-9, maximum 9) with the decode of REQ-015 for illegal values.

Verification
REQ-022 Hold reset=0 for 3 clk cycles, then toggle clk -> count=0 and BCD_output=7E throughout.
REQ-023 Release reset with mode=0 and run 12 edges (decade) -> count sequence 1..9, 0, 1, 2 with BCD_output matching REQ-014 on each value.
REQ-024 From count=0 set mode=1 and run 3 edges -> count 9, 8, 7 (decade) or 15, 14, 13 (hex build).
REQ-025 Assert reset=0 between clk edges while count=5 -> count=0 and BCD_output=7E immediately, before the next edge.
REQ-026 Hex build, mode=0 from 0, run 16 edges -> count reaches 15 with BCD_output=47, then wraps to 0 with 7E.
REQ-027 Toggle mode every edge starting from count=3 -> count alternates 4, 3, 4, 3.
